// File: rtl/stage3.sv
// -----------------------------------------------------------------------------
// stage3 - keyed rotate/XOR round engine, downstream of stage2.
//
// A rising edge on stg2_done captures the stage-2 word and the key. The engine
// then runs ROUNDS rounds, one per clock. Each round is
//     work <= rotl(work, rot) ^ (msk_en ? MASK : 0) ^ k
// where rot = key_bits[3:2] + 1 and msk_en = key_bits[4]. The result appears
// on stg3_out together with a level done flag. Only one word is in flight.
//
// Parameters
//   WIDTH   data width; must match the stage-2 output width
//   ROUNDS  rounds per word, 1..15 (the round counter is 4 bits)
//
// Ports
//   clk3       in   1      stage clock, rising edge
//   rst        in   1      asynchronous reset, active low
//   key_bits   in   5      key; only [4:2] is used
//   stg2_out   in   WIDTH  data word from stage2
//   stg2_done  in   1      stage2 done level; its rising edge starts a job
//   busy       out  1      high while rounds are in progress
//   done       out  1      level; stg3_out holds a valid result
//   stg3_out   out  WIDTH  result word
// -----------------------------------------------------------------------------
module stage3 #(
    parameter int unsigned WIDTH  = 17,
    parameter int unsigned ROUNDS = 4
) (
    input  logic             clk3,
    input  logic             rst,
    input  logic [4:0]       key_bits,
    input  logic [WIDTH-1:0] stg2_out,
    input  logic             stg2_done,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] stg3_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Even-index bits set (17'h15555 at WIDTH=17).
    localparam logic [2*WIDTH-1:0] MASK_REP = {WIDTH{2'b01}};
    localparam logic [WIDTH-1:0]   MASK     = MASK_REP[WIDTH-1:0];
    localparam logic [3:0]         LAST_K   = 4'(ROUNDS - 1);

    // Rotate left modulo WIDTH: the doubled word shifted left leaves the
    // wrapped result in its upper half (valid for r <= WIDTH).
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] w,
                                              input logic [2:0]       r);
        logic [2*WIDTH-1:0] dbl;
        dbl = {w, w} << r;
        return dbl[2*WIDTH-1:WIDTH];
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [2:0]         rot_q, rot_d;
    logic               msk_q, msk_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               stg2_done_q;

    logic               start;
    logic [WIDTH-1:0]   round_val;
    logic               unused_key;

    assign unused_key = ^key_bits[1:0];

    // Edge detect on the stage-2 done level; the delay register tracks in
    // every state so a level held across completion cannot retrigger.
    assign start = stg2_done & ~stg2_done_q;

    assign round_val = rotl(work_q, rot_q) ^ (msk_q ? MASK : '0) ^ WIDTH'(cnt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        rot_d   = rot_q;
        msk_d   = msk_q;
        busy_d  = busy_q;
        done_d  = done_q;
        out_d   = out_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = stg2_out;
                    rot_d   = {1'b0, key_bits[3:2]} + 3'd1;
                    msk_d   = key_bits[4];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = round_val;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST_K) begin
                    out_d   = round_val;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk3 or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            rot_q       <= '0;
            msk_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_q       <= '0;
            stg2_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            rot_q       <= rot_d;
            msk_q       <= msk_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_q       <= out_d;
            stg2_done_q <= stg2_done;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign stg3_out = out_q;

endmodule
